// File: rtl/iob_eth_rx_filter_pkg.sv
// Shared definitions for the Ethernet RX address/length filter.
//   rx_state_t      : filter FSM state encoding
//   ETH_MAC_LEN     : number of destination-address bytes at the head of a frame
//   ETH_BCAST_BYTE  : broadcast address byte value
//   mac_byte()      : selects destination byte idx (0 = MSB) from a 48-bit MAC
package iob_eth_rx_filter_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RECV,
        CHK,
        REPORT,
        DROP,
        WAITREL
    } rx_state_t;

    localparam int unsigned ETH_MAC_LEN    = 6;
    localparam logic [7:0]  ETH_BCAST_BYTE = 8'hFF;
    localparam int unsigned HDR_CNT_W      = 3;

    // Byte 0 of the destination address is carried in mac[47:40].
    function automatic logic [7:0] mac_byte(input logic [47:0] mac, input logic [2:0] idx);
        logic [7:0] b;
        case (idx)
            3'd0:    b = mac[47:40];
            3'd1:    b = mac[39:32];
            3'd2:    b = mac[31:24];
            3'd3:    b = mac[23:16];
            3'd4:    b = mac[15:8];
            3'd5:    b = mac[7:0];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/iob_eth_mac_match.sv
// Destination-address match flags, updated one header byte at a time.
//   rx_clk_i, arst_i : clock, asynchronous active-high reset
//   clr_i            : re-arm all flags to 1 for the next frame
//   en_i             : header byte write (idx_i < 6)
//   idx_i, data_i    : header byte position and value
//   mac_addr_i       : local MAC address
//   uc_ok_o          : every header byte so far matched the local MAC
//   bc_ok_o          : every header byte so far was 8'hFF
//   mc_o             : group bit (bit 0) of destination byte 0
module iob_eth_mac_match
    import iob_eth_rx_filter_pkg::*;
(
    input  logic        rx_clk_i,
    input  logic        arst_i,
    input  logic        clr_i,
    input  logic        en_i,
    input  logic [2:0]  idx_i,
    input  logic [7:0]  data_i,
    input  logic [47:0] mac_addr_i,
    output logic        uc_ok_o,
    output logic        bc_ok_o,
    output logic        mc_o
);

    // Flags rest at 1 so the first header byte effectively loads them.
    always_ff @(posedge rx_clk_i or posedge arst_i) begin
        if (arst_i) begin
            uc_ok_o <= 1'b1;
            bc_ok_o <= 1'b1;
            mc_o    <= 1'b1;
        end else if (clr_i) begin
            uc_ok_o <= 1'b1;
            bc_ok_o <= 1'b1;
            mc_o    <= 1'b1;
        end else if (en_i) begin
            uc_ok_o <= uc_ok_o & (data_i == mac_byte(mac_addr_i, idx_i));
            bc_ok_o <= bc_ok_o & (data_i == ETH_BCAST_BYTE);
            if (idx_i == 3'd0) begin
                mc_o <= data_i[0];
            end
        end
    end

endmodule

// File: rtl/iob_eth_rx_filter.sv
// Ethernet RX frame filter between the MII receiver and the RX buffer/DMA.
// Forwards buffer writes with one register stage, checks the destination MAC,
// measures frame length and either reports the frame to the DMA (ready/ack)
// or drops it, acknowledging the receiver itself and counting the drop.
// Optional build macro IOB_ETH_RX_FILTER_MCAST_EN: accept multicast frames
// and expose frame_mcast_o.
//   rx_clk_i, arst_i                 : clock, asynchronous active-high reset
//   wr_i, addr_i, data_i             : buffer write from the receiver
//   data_rcvd_i, crc_err_i           : frame complete level, CRC error
//   rcv_ack_o                        : one-cycle acknowledge to the receiver
//   mac_addr_i, promisc_i            : local MAC, accept-all mode
//   buf_wr_o, buf_addr_o, buf_data_o : forwarded buffer write
//   frame_rdy_o, frame_len_o, frame_bcast_o (, frame_mcast_o) : DMA report
//   frame_ack_i                      : DMA consumed the reported frame
//   drop_cnt_o                       : saturating dropped-frame count
module iob_eth_rx_filter
    import iob_eth_rx_filter_pkg::*;
#(
    parameter int unsigned BUF_ADDR_W = 11,
    parameter int unsigned MIN_LEN    = 64,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                  rx_clk_i,
    input  logic                  arst_i,
    input  logic                  wr_i,
    input  logic [BUF_ADDR_W-1:0] addr_i,
    input  logic [7:0]            data_i,
    input  logic                  data_rcvd_i,
    input  logic                  crc_err_i,
    output logic                  rcv_ack_o,
    input  logic [47:0]           mac_addr_i,
    input  logic                  promisc_i,
    output logic                  buf_wr_o,
    output logic [BUF_ADDR_W-1:0] buf_addr_o,
    output logic [7:0]            buf_data_o,
    output logic                  frame_rdy_o,
    output logic [BUF_ADDR_W-1:0] frame_len_o,
    output logic                  frame_bcast_o,
`ifdef IOB_ETH_RX_FILTER_MCAST_EN
    output logic                  frame_mcast_o,
`endif
    input  logic                  frame_ack_i,
    output logic [CNT_W-1:0]      drop_cnt_o
);

    rx_state_t             state;
    logic                  rcvd_q;
    logic [HDR_CNT_W-1:0]  hdr_cnt;
    logic [BUF_ADDR_W-1:0] len;
    logic                  ovf;
    logic                  uc_ok;
    logic                  bc_ok;
    logic                  mc;

    logic                  rcvd_rise;
    logic                  trk;
    logic                  hdr_wr;
    logic                  flag_clr;
    logic                  addr_ok;
    logic                  accept;

    // Frame tracking qualifiers and the accept decision used in CHK.
    always_comb begin
        rcvd_rise = data_rcvd_i & ~rcvd_q;
        // In IDLE only the first byte of a frame (address 0) is tracked.
        trk       = wr_i & ((state == RECV) | ((state == IDLE) & (addr_i == '0)));
        hdr_wr    = trk & (addr_i < BUF_ADDR_W'(ETH_MAC_LEN));
        flag_clr  = (state == WAITREL) & ~data_rcvd_i;
`ifdef IOB_ETH_RX_FILTER_MCAST_EN
        addr_ok   = promisc_i | uc_ok | bc_ok | mc;
`else
        addr_ok   = promisc_i | uc_ok | bc_ok;
`endif
        accept    = addr_ok & ~crc_err_i
                  & (hdr_cnt == HDR_CNT_W'(ETH_MAC_LEN))
                  & (len >= BUF_ADDR_W'(MIN_LEN))
                  & ~ovf;
    end

`ifndef IOB_ETH_RX_FILTER_MCAST_EN
    logic mc_unused;
    assign mc_unused = mc;
`endif

    iob_eth_mac_match u_mac_match (
        .rx_clk_i   (rx_clk_i),
        .arst_i     (arst_i),
        .clr_i      (flag_clr),
        .en_i       (hdr_wr),
        .idx_i      (addr_i[2:0]),
        .data_i     (data_i),
        .mac_addr_i (mac_addr_i),
        .uc_ok_o    (uc_ok),
        .bc_ok_o    (bc_ok),
        .mc_o       (mc)
    );

    // Forwarding stage, frame measurement and filter FSM.
    always_ff @(posedge rx_clk_i or posedge arst_i) begin
        if (arst_i) begin
            state         <= IDLE;
            rcvd_q        <= 1'b0;
            hdr_cnt       <= '0;
            len           <= '0;
            ovf           <= 1'b0;
            buf_wr_o      <= 1'b0;
            buf_addr_o    <= '0;
            buf_data_o    <= '0;
            rcv_ack_o     <= 1'b0;
            frame_rdy_o   <= 1'b0;
            frame_len_o   <= '0;
            frame_bcast_o <= 1'b0;
`ifdef IOB_ETH_RX_FILTER_MCAST_EN
            frame_mcast_o <= 1'b0;
`endif
            drop_cnt_o    <= '0;
        end else begin
            buf_wr_o   <= wr_i;
            buf_addr_o <= addr_i;
            buf_data_o <= data_i;
            rcvd_q     <= data_rcvd_i;
            rcv_ack_o  <= 1'b0;

            if (trk) begin
                len <= addr_i + BUF_ADDR_W'(1);
                if (addr_i == '1) begin
                    ovf <= 1'b1;
                end
                if (hdr_wr && (hdr_cnt != HDR_CNT_W'(ETH_MAC_LEN))) begin
                    hdr_cnt <= hdr_cnt + HDR_CNT_W'(1);
                end
            end

            case (state)
                IDLE: begin
                    // A completion with no bytes written is checked (and dropped) as a runt.
                    if (rcvd_rise) begin
                        state <= CHK;
                    end else if (trk) begin
                        state <= RECV;
                    end
                end
                RECV: begin
                    if (rcvd_rise) begin
                        state <= CHK;
                    end
                end
                CHK: begin
                    if (accept) begin
                        frame_rdy_o   <= 1'b1;
                        frame_len_o   <= len;
                        frame_bcast_o <= bc_ok;
`ifdef IOB_ETH_RX_FILTER_MCAST_EN
                        frame_mcast_o <= mc;
`endif
                        state         <= REPORT;
                    end else begin
                        state <= DROP;
                    end
                end
                REPORT: begin
                    if (frame_ack_i) begin
                        frame_rdy_o <= 1'b0;
                        rcv_ack_o   <= 1'b1;
                        state       <= WAITREL;
                    end
                end
                DROP: begin
                    rcv_ack_o <= 1'b1;
                    if (drop_cnt_o != '1) begin
                        drop_cnt_o <= drop_cnt_o + CNT_W'(1);
                    end
                    state <= WAITREL;
                end
                WAITREL: begin
                    // Match flags are re-armed in the match block on the same condition.
                    if (!data_rcvd_i) begin
                        hdr_cnt <= '0;
                        len     <= '0;
                        ovf     <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_iob_eth_rx_filter.sv
// Self-checking bench for iob_eth_rx_filter: directed and random frames,
// a frame-level reference model feeding a scoreboard queue, and a monitor
// that checks forwarding, DMA reports and receiver acknowledges.
module tb_iob_eth_rx_filter;

    localparam int unsigned BUF_ADDR_W = 11;
    localparam int unsigned MIN_LEN    = 64;
    localparam int unsigned CNT_W      = 4;
    localparam logic [47:0] MAC        = 48'h0102_0304_0506;

    logic                  rx_clk_i;
    logic                  arst_i;
    logic                  wr_i;
    logic [BUF_ADDR_W-1:0] addr_i;
    logic [7:0]            data_i;
    logic                  data_rcvd_i;
    logic                  crc_err_i;
    logic                  rcv_ack_o;
    logic [47:0]           mac_addr_i;
    logic                  promisc_i;
    logic                  buf_wr_o;
    logic [BUF_ADDR_W-1:0] buf_addr_o;
    logic [7:0]            buf_data_o;
    logic                  frame_rdy_o;
    logic [BUF_ADDR_W-1:0] frame_len_o;
    logic                  frame_bcast_o;
`ifdef IOB_ETH_RX_FILTER_MCAST_EN
    logic                  frame_mcast_o;
`endif
    logic                  frame_ack_i;
    logic [CNT_W-1:0]      drop_cnt_o;

    iob_eth_rx_filter #(
        .BUF_ADDR_W (BUF_ADDR_W),
        .MIN_LEN    (MIN_LEN),
        .CNT_W      (CNT_W)
    ) dut (
        .rx_clk_i      (rx_clk_i),
        .arst_i        (arst_i),
        .wr_i          (wr_i),
        .addr_i        (addr_i),
        .data_i        (data_i),
        .data_rcvd_i   (data_rcvd_i),
        .crc_err_i     (crc_err_i),
        .rcv_ack_o     (rcv_ack_o),
        .mac_addr_i    (mac_addr_i),
        .promisc_i     (promisc_i),
        .buf_wr_o      (buf_wr_o),
        .buf_addr_o    (buf_addr_o),
        .buf_data_o    (buf_data_o),
        .frame_rdy_o   (frame_rdy_o),
        .frame_len_o   (frame_len_o),
        .frame_bcast_o (frame_bcast_o),
`ifdef IOB_ETH_RX_FILTER_MCAST_EN
        .frame_mcast_o (frame_mcast_o),
`endif
        .frame_ack_i   (frame_ack_i),
        .drop_cnt_o    (drop_cnt_o)
    );

    initial rx_clk_i = 1'b0;
    always #5 rx_clk_i = ~rx_clk_i;

    typedef struct {
        bit          acc;
        int unsigned len;
        bit          bcast;
        bit          mcast;
        int unsigned drop;
    } exp_t;

    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int unsigned exp_drop = 0;

    task automatic chk(input string name, input longint unsigned act, input longint unsigned req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, " rcv_ack_o"},     rcv_ack_o, 0);
        chk({tag, " buf_wr_o"},      buf_wr_o, 0);
        chk({tag, " buf_addr_o"},    buf_addr_o, 0);
        chk({tag, " buf_data_o"},    buf_data_o, 0);
        chk({tag, " frame_rdy_o"},   frame_rdy_o, 0);
        chk({tag, " frame_len_o"},   frame_len_o, 0);
        chk({tag, " frame_bcast_o"}, frame_bcast_o, 0);
        chk({tag, " drop_cnt_o"},    drop_cnt_o, 0);
`ifdef IOB_ETH_RX_FILTER_MCAST_EN
        chk({tag, " frame_mcast_o"}, frame_mcast_o, 0);
`endif
    endtask

    // Frame-level reference: outcome from destination bytes, length, CRC and mode.
    task automatic model(input logic [47:0] dst, input int n, input bit crc, input bit prom,
                         output exp_t e);
        logic [7:0] dbytes [6];
        logic [7:0] mbytes [6];
        int         hdr;
        bit         uc, bc, mc, aok;
        for (int k = 0; k < 6; k++) begin
            dbytes[k] = dst[8*(5-k) +: 8];
            mbytes[k] = MAC[8*(5-k) +: 8];
        end
        hdr = (n < 6) ? n : 6;
        uc  = 1'b1;
        bc  = 1'b1;
        for (int k = 0; k < hdr; k++) begin
            if (dbytes[k] != mbytes[k]) uc = 1'b0;
            if (dbytes[k] != 8'hFF)     bc = 1'b0;
        end
        mc  = dbytes[0][0];
        aok = prom || uc || bc;
`ifdef IOB_ETH_RX_FILTER_MCAST_EN
        aok = aok || mc;
`endif
        e.acc   = aok && !crc && (n >= 6) && (n >= int'(MIN_LEN)) && (n < (1 << BUF_ADDR_W));
        e.len   = n;
        e.bcast = bc;
        e.mcast = mc;
        if (!e.acc && exp_drop < (1 << CNT_W) - 1) exp_drop++;
        e.drop  = exp_drop;
    endtask

    // Sends one frame, pushes its expected outcome, then plays the DMA side.
    task automatic send_frame(input logic [47:0] dst, input int n, input bit crc,
                              input bit prom, input bit gaps, input int stray_at);
        exp_t e;
        bit   done;
        promisc_i = prom;
        for (int i = 0; i < n; i++) begin
            @(negedge rx_clk_i);
            wr_i        = 1'b1;
            addr_i      = BUF_ADDR_W'(i);
            data_i      = (i < 6) ? dst[8*(5-i) +: 8] : 8'($urandom);
            frame_ack_i = (i == stray_at);
            if (gaps && $urandom_range(0, 3) == 0) begin
                @(negedge rx_clk_i);
                wr_i        = 1'b0;
                frame_ack_i = 1'b0;
            end
        end
        @(negedge rx_clk_i);
        wr_i        = 1'b0;
        data_i      = 8'h00;
        frame_ack_i = 1'b0;
        crc_err_i   = crc;
        data_rcvd_i = 1'b1;
        model(dst, n, crc, prom, e);
        exp_q.push_back(e);
        done = 1'b0;
        for (int t = 0; t < 400 && !done; t++) begin
            @(negedge rx_clk_i);
            if (rcv_ack_o) begin
                done = 1'b1;
            end else if (frame_rdy_o) begin
                repeat ($urandom_range(0, 3)) @(negedge rx_clk_i);
                frame_ack_i = 1'b1;
                @(negedge rx_clk_i);
                frame_ack_i = 1'b0;
                if (rcv_ack_o) done = 1'b1;
            end
        end
        chk("rcv_ack timeout", done, 1);
        data_rcvd_i = 1'b0;
        crc_err_i   = 1'b0;
        repeat ($urandom_range(1, 3)) @(negedge rx_clk_i);
    endtask

    // Monitor: forwarding every cycle, report and acknowledge events via the scoreboard.
    int unsigned            cyc = 0;
    int unsigned            rise_cyc = 0;
    int unsigned            ack_cyc = 0;
    bit                     drcv_prev = 1'b0;
    bit                     rdy_prev = 1'b0;
    bit                     rdy_seen = 1'b0;
    bit                     cap_ok = 1'b0;
    logic                   cap_wr;
    logic [BUF_ADDR_W-1:0]  cap_addr;
    logic [7:0]             cap_data;

    initial begin
        exp_t e;
        forever begin
            @(posedge rx_clk_i);
            cyc++;
            if (arst_i) begin
                drcv_prev = 1'b0;
                cap_ok    = 1'b0;
            end else begin
                if (data_rcvd_i && !drcv_prev) rise_cyc = cyc;
                drcv_prev = data_rcvd_i;
                if (frame_ack_i) ack_cyc = cyc;
                cap_ok   = 1'b1;
                cap_wr   = wr_i;
                cap_addr = addr_i;
                cap_data = data_i;
            end
            #1;
            if (arst_i) begin
                rdy_prev = 1'b0;
                rdy_seen = 1'b0;
            end else begin
                if (cap_ok)
                    chk("forward", {buf_wr_o, buf_addr_o, buf_data_o}, {cap_wr, cap_addr, cap_data});
                if (frame_rdy_o && !rdy_prev) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected frame_rdy", exp_q.size(), 1);
                    end else begin
                        e = exp_q[0];
                        chk("frame accepted", 1, e.acc);
                        chk("frame_len_o", frame_len_o, e.len);
                        chk("frame_bcast_o", frame_bcast_o, e.bcast);
`ifdef IOB_ETH_RX_FILTER_MCAST_EN
                        chk("frame_mcast_o", frame_mcast_o, e.mcast);
`endif
                        chk("rdy latency", cyc, rise_cyc + 1);
                    end
                    rdy_seen = 1'b1;
                end
                if (rcv_ack_o) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected rcv_ack", exp_q.size(), 1);
                    end else begin
                        e = exp_q.pop_front();
                        if (e.acc) begin
                            chk("rdy before ack", rdy_seen, 1);
                            chk("ack latency after frame_ack", cyc, ack_cyc);
                            chk("rdy low at ack", frame_rdy_o, 0);
                        end else begin
                            chk("dropped frame reported", rdy_seen, 0);
                            chk("drop ack latency", cyc, rise_cyc + 2);
                        end
                        chk("drop_cnt_o", drop_cnt_o, e.drop);
                    end
                    rdy_seen = 1'b0;
                end
                rdy_prev = frame_rdy_o;
            end
        end
    end

    initial begin
        logic [47:0] d;
        int          n;
        arst_i      = 1'b0;
        wr_i        = 1'b0;
        addr_i      = '0;
        data_i      = 8'h00;
        data_rcvd_i = 1'b0;
        crc_err_i   = 1'b0;
        mac_addr_i  = MAC;
        promisc_i   = 1'b0;
        frame_ack_i = 1'b0;
        #1 arst_i = 1'b1;
        #2 check_all_zero("reset");
        repeat (3) @(negedge rx_clk_i);
        arst_i = 1'b0;
        repeat (2) @(negedge rx_clk_i);

        // Stray DMA ack in IDLE, and a lone write at address 5 outside a frame.
        frame_ack_i = 1'b1;
        @(negedge rx_clk_i);
        frame_ack_i = 1'b0;
        wr_i   = 1'b1;
        addr_i = BUF_ADDR_W'(5);
        data_i = 8'hA5;
        @(posedge rx_clk_i);
        #1 chk("forward 1/5/A5", {buf_wr_o, buf_addr_o, buf_data_o}, {1'b1, 11'd5, 8'hA5});
        @(negedge rx_clk_i);
        wr_i = 1'b0;
        repeat (2) @(negedge rx_clk_i);

        // Directed frames.
        send_frame(MAC, 100, 0, 0, 0, -1);
        send_frame(48'hFFFF_FFFF_FFFF, 64, 0, 0, 0, -1);
        send_frame(48'hFFFF_FFFF_FFFF, 63, 0, 0, 0, -1);
        send_frame(48'h0A0B_0C0D_0E0F, 80, 0, 0, 0, -1);
        send_frame(48'h0A0B_0C0D_0E0F, 80, 0, 1, 0, -1);
        send_frame(MAC, 80, 1, 0, 0, -1);
        send_frame(MAC, 70, 0, 0, 0, 10);
        send_frame(48'h0100_5E00_0001, 70, 0, 0, 0, -1);
        send_frame(MAC, 5, 0, 0, 0, -1);
        send_frame(MAC, 0, 0, 0, 0, -1);

        // Reset in the middle of a frame.
        promisc_i = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge rx_clk_i);
            wr_i   = 1'b1;
            addr_i = BUF_ADDR_W'(i);
            data_i = (i < 6) ? MAC[8*(5-i) +: 8] : 8'($urandom);
        end
        @(negedge rx_clk_i);
        wr_i   = 1'b0;
        arst_i = 1'b1;
        exp_drop = 0;
        #1 check_all_zero("mid-frame reset");
        repeat (2) @(negedge rx_clk_i);
        arst_i = 1'b0;
        @(negedge rx_clk_i);
        send_frame(MAC, 64, 0, 0, 0, -1);

        // Random frames.
        for (int f = 0; f < 25; f++) begin
            case ($urandom_range(0, 5))
                0:       n = $urandom_range(0, 10);
                1:       n = 63;
                2:       n = 64;
                3:       n = 65;
                default: n = $urandom_range(20, 140);
            endcase
            case ($urandom_range(0, 4))
                0:       d = MAC;
                1:       d = 48'hFFFF_FFFF_FFFF;
                2:       d = {16'($urandom), $urandom};
                3:       d = MAC ^ (48'h1 << (8 * $urandom_range(0, 5)));
                default: d = {40'h01_00_5E_00_00, 8'($urandom)};
            endcase
            send_frame(d, n, ($urandom_range(0, 4) == 0), ($urandom_range(0, 4) == 0), 1, -1);
        end

        // Drop counter saturation.
        for (int f = 0; f < (1 << CNT_W) + 3; f++) begin
            send_frame(MAC, 0, 0, 0, 0, -1);
        end
        chk("drop_cnt saturated", drop_cnt_o, (1 << CNT_W) - 1);

        for (int t = 0; t < 100 && exp_q.size() != 0; t++) @(negedge rx_clk_i);
        chk("scoreboard drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
